dac_ramp_sequencer: RTL and testbench

- Sequences slew-limited updates of an 8-bit AD5601 DAC code. It drives the direct `dac_reg` / `dac_reg_valid_stb` / `dac_reg_updated_stb` handshake of `dac_ad5601_ctrl_mmi`.
- A requester such as an AGC loop or bring-up logic posts a target code. The block steps the DAC toward that target in bounded increments.
- Each step waits for the SPI write to complete, then holds for a programmable dwell time before the next step.
- Sits between gain-control logic and `dac_ad5601_ctrl_mmi`, in the same clock domain.

---
 rtl/dac_ramp_pkg.sv | 32 +++
 rtl/dac_ramp_sequencer.sv | 148 ++++++++++++++
 tb/tb_dac_ramp_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ramp_pkg.sv
// Shared types and the slew-limit clamp for the DAC ramp sequencer.
// next_code() works at MAX_CODE_W bits; callers zero-extend and truncate.
package dac_ramp_pkg;

    localparam int unsigned MAX_CODE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DWELL
    } dac_ramp_state_t;

    // One step from current toward target, never past it; step 0 acts as 1.
    function automatic logic [MAX_CODE_W-1:0] next_code(
        input logic [MAX_CODE_W-1:0] current,
        input logic [MAX_CODE_W-1:0] target,
        input logic [MAX_CODE_W-1:0] step
    );
        logic [MAX_CODE_W-1:0] s;
        logic [MAX_CODE_W:0]   diff;
        s = (step == '0) ? MAX_CODE_W'(1) : step;
        if (target >= current) begin
            diff = {1'b0, target} - {1'b0, current};
            next_code = (diff <= {1'b0, s}) ? target : current + s;
        end else begin
            diff = {1'b0, current} - {1'b0, target};
            next_code = (diff <= {1'b0, s}) ? target : current - s;
        end
    endfunction

endpackage

// File: rtl/dac_ramp_sequencer.sv
// Slew-limited sequencer driving the AD5601 controller write handshake.
// Steps toward a posted target, waits for each ack, then dwells.
module dac_ramp_sequencer
    import dac_ramp_pkg::*;
#(
    parameter int unsigned            CODE_WIDTH  = 8,
    parameter int unsigned            DWELL_WIDTH = 16,
    parameter int unsigned            ACK_TIMEOUT = 4096,
    parameter logic [CODE_WIDTH-1:0]  INIT_CODE   = '0
) (
    input  logic                   clk,
    input  logic                   sreset,
    input  logic                   enable,
    input  logic [CODE_WIDTH-1:0]  target_code,
    input  logic                   target_valid,
    input  logic [CODE_WIDTH-1:0]  step_size,
    input  logic [DWELL_WIDTH-1:0] dwell_cycles,
    input  logic                   clear_err,
    output logic [CODE_WIDTH-1:0]  dac_reg,
    output logic                   dac_reg_valid_stb,
    input  logic                   dac_reg_updated_stb,
    output logic [CODE_WIDTH-1:0]  current_code,
    output logic                   busy,
    output logic                   at_target,
    output logic                   timeout_err
);

    localparam int unsigned ACK_W =
        (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    dac_ramp_state_t r_state;
    dac_ramp_state_t w_next_state;

    logic [CODE_WIDTH-1:0]  r_target;
    logic [CODE_WIDTH-1:0]  r_current;
    logic [CODE_WIDTH-1:0]  r_dac;
    logic                   r_stb;
    logic                   r_err;
    logic [ACK_W-1:0]       r_ack_cnt;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;

    logic [CODE_WIDTH-1:0]  w_next_code;
    logic                   w_ack_expired;
    logic                   w_timeout;
    logic                   w_take_step;
    logic                   w_dwell_done;

    assign w_next_code = CODE_WIDTH'(next_code(
        MAX_CODE_W'(r_current),
        MAX_CODE_W'(r_target),
        MAX_CODE_W'(step_size)));

    assign w_ack_expired = (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
    assign w_dwell_done  = (r_dwell_cnt == DWELL_WIDTH'(1));

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_take_step  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable && !r_err && (r_target != r_current)) begin
                    w_next_state = ST_ISSUE;
                    w_take_step  = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (dac_reg_updated_stb) begin
                    w_next_state = (dwell_cycles != '0) ? ST_DWELL : ST_IDLE;
                end else if (w_ack_expired) begin
                    w_next_state = ST_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            ST_DWELL: begin
                if (w_dwell_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_target    <= INIT_CODE;
            r_current   <= INIT_CODE;
            r_dac       <= INIT_CODE;
            r_stb       <= 1'b0;
            r_err       <= 1'b0;
            r_ack_cnt   <= '0;
            r_dwell_cnt <= '0;
        end else begin
            if (target_valid) begin
                r_target <= target_code;
            end
            // Strobe is registered out of ISSUE, so it lands in WAIT_ACK.
            r_stb <= (r_state == ST_ISSUE);
            if (w_take_step) begin
                r_dac <= w_next_code;
            end
            unique case (r_state)
                ST_ISSUE: begin
                    r_ack_cnt <= '0;
                end
                ST_WAIT_ACK: begin
                    if (dac_reg_updated_stb) begin
                        r_current   <= r_dac;
                        r_dwell_cnt <= dwell_cycles;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                    end
                end
                ST_DWELL: begin
                    r_dwell_cnt <= r_dwell_cnt - DWELL_WIDTH'(1);
                end
                default: begin
                end
            endcase
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign dac_reg           = r_dac;
    assign dac_reg_valid_stb = r_stb;
    assign current_code      = r_current;
    assign timeout_err       = r_err;
    assign busy              = (r_state != ST_IDLE);
    assign at_target         = (r_state == ST_IDLE) && (r_current == r_target);

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Self-checking bench for dac_ramp_sequencer: vector table, corner
// sequences and randomized ramps against an arithmetic reference model.
module tb_dac_ramp_sequencer;

    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        sreset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  target_code = '0;
    logic        target_valid = 1'b0;
    logic [7:0]  step_size = '0;
    logic [15:0] dwell_cycles = '0;
    logic        clear_err = 1'b0;
    logic        ack;
    logic [7:0]  dac_reg;
    logic        dac_reg_valid_stb;
    logic [7:0]  current_code;
    logic        busy;
    logic        at_target;
    logic        timeout_err;

    always #5 clk = ~clk;

    dac_ramp_sequencer #(
        .CODE_WIDTH (8),
        .DWELL_WIDTH(16),
        .ACK_TIMEOUT(TO),
        .INIT_CODE  (8'd0)
    ) dut (
        .clk                (clk),
        .sreset             (sreset),
        .enable             (enable),
        .target_code        (target_code),
        .target_valid       (target_valid),
        .step_size          (step_size),
        .dwell_cycles       (dwell_cycles),
        .clear_err          (clear_err),
        .dac_reg            (dac_reg),
        .dac_reg_valid_stb  (dac_reg_valid_stb),
        .dac_reg_updated_stb(ack),
        .current_code       (current_code),
        .busy               (busy),
        .at_target          (at_target),
        .timeout_err        (timeout_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state
    int m_cur = 0;
    int m_tgt = 0;
    int m_last = 0;
    int stb_q[$];
    int pend = 0;
    bit outstanding = 0;
    bit ack_en = 1;
    int ack_lat = 3;
    bit spur = 0;

    typedef struct {
        int tgt;
        int step;
        int dwell;
        int lat;
        int exp_writes;
        int exp_final;
    } vec_t;

    vec_t vt[7];

    function automatic int ref_next(int cur, int tgt, int step);
        int s;
        s = (step == 0) ? 1 : step;
        if (tgt > cur) return (tgt - cur <= s) ? tgt : cur + s;
        return (cur - tgt <= s) ? tgt : cur - s;
    endfunction

    function automatic int ref_writes(int cur, int tgt, int step);
        int n = 0;
        int c = cur;
        while (c != tgt) begin
            c = ref_next(c, tgt, step);
            n++;
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // DAC controller stand-in plus strobe scoreboard
    always @(negedge clk) begin
        ack = 1'b0;
        if (sreset) begin
            pend = 0;
            outstanding = 0;
        end else begin
            if (outstanding) chk("dac_reg_stable", int'(dac_reg), m_last);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ack = 1'b1;
                    m_cur = m_last;
                    outstanding = 0;
                end
            end
            if (spur) ack = 1'b1;
            if (dac_reg_valid_stb) begin
                stb_q.push_back(cyc);
                chk("no_double_strobe", int'(outstanding), 0);
                m_last = ref_next(m_cur, m_tgt, int'(step_size));
                chk("strobe_code", int'(dac_reg), m_last);
                outstanding = 1;
                if (ack_en) begin
                    if (ack_lat <= 1) begin
                        ack = 1'b1;
                        m_cur = m_last;
                        outstanding = 0;
                    end else begin
                        pend = ack_lat - 1;
                    end
                end
            end
            if (outstanding && timeout_err && pend == 0) outstanding = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_target(int t, output int c0);
        target_code = 8'(t);
        target_valid = 1'b1;
        m_tgt = t;
        c0 = cyc;
        tick();
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        tick();
        tick();
        while (!(!busy && at_target) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) chk({name, "_idle_timeout"}, n, 0);
    endtask

    task automatic wait_strobes(string name, int cnt);
        int n = 0;
        while (stb_q.size() < cnt && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk({name, "_strobe_timeout"}, stb_q.size(), cnt);
    endtask

    initial begin
        int c0, n0, s0, n, cur0, tgt, stp;
        #300_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n0, s0, n, cur0, tgt, stp;

        vt[0] = '{100, 10, 0, 3, 10, 100};
        vt[1] = '{5,   40, 0, 3, 3,  5};
        vt[2] = '{0,   40, 0, 2, 1,  0};
        vt[3] = '{3,   0,  0, 1, 3,  3};
        vt[4] = '{200, 50, 2, 4, 4,  200};
        vt[5] = '{255, 255, 0, 1, 1, 255};
        vt[6] = '{0,   100, 1, 2, 3, 0};

        repeat (3) tick();
        sreset = 1'b0;
        tick();
        chk("rst_dac_reg", int'(dac_reg), 0);
        chk("rst_valid_stb", int'(dac_reg_valid_stb), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_current", int'(current_code), 0);

        enable = 1'b1;
        foreach (vt[i]) begin
            step_size = 8'(vt[i].step);
            dwell_cycles = 16'(vt[i].dwell);
            ack_lat = vt[i].lat;
            n0 = stb_q.size();
            pulse_target(vt[i].tgt, c0);
            wait_idle("vec");
            chk("vec_writes", stb_q.size() - n0, vt[i].exp_writes);
            chk("vec_final", int'(current_code), vt[i].exp_final);
            chk("vec_at_target", int'(at_target), 1);
            chk("vec_busy", int'(busy), 0);
            if (stb_q.size() > n0) chk("vec_latency", stb_q[n0] - c0, 3);
        end

        // retarget while a step is in flight
        pulse_target(0, c0);
        wait_idle("ret0");
        step_size = 8'd10;
        dwell_cycles = 16'd0;
        ack_lat = 6;
        n0 = stb_q.size();
        pulse_target(100, c0);
        wait_strobes("ret", n0 + 3);
        pulse_target(20, c0);
        wait_idle("ret");
        chk("ret_writes", stb_q.size() - n0, 4);
        chk("ret_final", int'(current_code), 20);

        // spurious acks while idle are ignored
        spur = 1;
        repeat (3) tick();
        spur = 0;
        tick();
        chk("spur_current", int'(current_code), 20);
        chk("spur_busy", int'(busy), 0);

        // ack timeout, blocked issue, then recovery
        ack_en = 0;
        n0 = stb_q.size();
        pulse_target(60, c0);
        wait_strobes("to", n0 + 1);
        s0 = stb_q[n0];
        n = 0;
        while (!timeout_err && n < TO + 50) begin
            tick();
            n++;
        end
        chk("to_rise_cycles", cyc - s0, TO);
        chk("to_current", int'(current_code), 20);
        chk("to_busy", int'(busy), 0);
        n0 = stb_q.size();
        repeat (40) tick();
        chk("to_blocked", stb_q.size() - n0, 0);
        chk("to_sticky", int'(timeout_err), 1);
        ack_en = 1;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("to_cleared", int'(timeout_err), 0);
        wait_idle("to");
        chk("to_resume_writes", stb_q.size() - n0, 4);
        chk("to_resume_final", int'(current_code), 60);

        // dwell spacing and enable drop mid-dwell
        dwell_cycles = 16'd5;
        ack_lat = 3;
        n0 = stb_q.size();
        pulse_target(0, c0);
        wait_strobes("dw", n0 + 2);
        chk("dw_spacing", stb_q[n0 + 1] - stb_q[n0], 3 + 5 + 2);
        repeat (3) tick();
        chk("dw_in_dwell", int'(busy), 1);
        enable = 1'b0;
        repeat (30) tick();
        chk("dw_paused_writes", stb_q.size() - n0, 2);
        chk("dw_paused_busy", int'(busy), 0);
        chk("dw_paused_current", int'(current_code), 40);
        chk("dw_paused_at_target", int'(at_target), 0);
        enable = 1'b1;
        wait_idle("dw");
        chk("dw_resume_writes", stb_q.size() - n0, 6);
        chk("dw_resume_final", int'(current_code), 0);

        // randomized ramps
        for (int k = 0; k < 30; k++) begin
            stp = $urandom_range(0, 64);
            cur0 = int'(current_code);
            if (stp < 4) begin
                tgt = cur0 + int'($urandom_range(0, 16)) - 8;
                if (tgt < 0) tgt = 0;
                if (tgt > 255) tgt = 255;
            end else begin
                tgt = $urandom_range(0, 255);
            end
            step_size = 8'(stp);
            dwell_cycles = 16'($urandom_range(0, 3));
            ack_lat = $urandom_range(1, 4);
            n0 = stb_q.size();
            pulse_target(tgt, c0);
            wait_idle("rnd");
            chk("rnd_final", int'(current_code), tgt);
            chk("rnd_model", m_cur, tgt);
            chk("rnd_writes", stb_q.size() - n0, ref_writes(cur0, tgt, stp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
